// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver:
//   - SEG_0..SEG_F : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_OFF      : all segments dark
//   - scan_state_e : per-slot scan FSM states (BLANK dead time, DRIVE digit on)
//   - seg_active_low() : converts an active-high pattern to the pin polarity
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // The display is common-anode, so a lit segment is a low pin.
    function automatic logic [6:0] seg_active_low(input logic [6:0] seg_hi);
        return ~seg_hi;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex digit decoder.
//   i_nibble : 4-bit hex value 0..F
//   o_seg    : 7-bit active-high segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Nibble to segment pattern lookup.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// value update and optional leading-zero blanking.
//
// Parameters:
//   DIGITS       number of digits (2..8)
//   PRESCALE_N   each digit slot lasts 2^PRESCALE_N clocks
//   BLANK_CYCLES anodes-off dead time at the start of every slot (1..2^N-1)
// Ports:
//   clk        system clock
//   n_reset    synchronous active-low reset
//   load       one-cycle strobe capturing value/dp_in/blank_lz into the shadow
//   value      4*DIGITS hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   dp_in      decimal-point request per digit
//   blank_lz   leading-zero blanking enable
//   seg_n      segments {g..a}, active-low, registered
//   dp_n       decimal point, active-low, registered
//   an_n       anode enables, active-low, at most one low, registered
//   frame_done one-cycle pulse per digit-index wrap to 0, registered
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE_N   = 16,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESCALE_N-1:0] PRESC_ONE  = PRESCALE_N'(1);
    // Last BLANK count; the FSM enters DRIVE as the counter reaches BLANK_CYCLES.
    localparam logic [PRESCALE_N-1:0] BLANK_LAST = PRESCALE_N'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0]      DIGIT_ONE  = DIG_W'(1);
    localparam logic [DIG_W-1:0]      DIGIT_LAST = DIG_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]     AN_ALL_OFF = {DIGITS{1'b1}};
    localparam logic [DIGITS-1:0]     AN_BIT0    = {{(DIGITS-1){1'b0}}, 1'b1};

    // Scan timing state
    logic [PRESCALE_N-1:0]  r_presc;
    logic [DIG_W-1:0]       r_digit;
    scan_state_e            r_state;
    scan_state_e            w_state_next;

    // Shadow (host side) and active (displayed) copies
    logic [4*DIGITS-1:0]    r_shadow_val;
    logic [DIGITS-1:0]      r_shadow_dp;
    logic                   r_shadow_lz;
    logic                   r_pending;
    logic [4*DIGITS-1:0]    r_act_val;
    logic [DIGITS-1:0]      r_act_dp;
    logic                   r_act_lz;

    // Output registers
    logic [6:0]             r_seg_n;
    logic                   r_dp_n;
    logic [DIGITS-1:0]      r_an_n;
    logic                   r_frame_done;

    // Combinational helpers
    logic                   w_slot_end;
    logic                   w_wrap;
    logic [3:0]             w_nibble;
    logic [6:0]             w_seg_on;
    logic [DIGITS-1:0]      w_blank_mask;
    logic                   w_digit_blank;
    logic                   w_digit_dp;
    logic [DIGITS-1:0]      w_onehot;
    logic [6:0]             w_seg_n_next;
    logic                   w_dp_n_next;
    logic [DIGITS-1:0]      w_an_n_next;

    assign w_slot_end = &r_presc;
    assign w_wrap     = w_slot_end && (r_digit == DIGIT_LAST);

    // Free-running prescaler and digit index, advancing at every slot end.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_presc <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
            if (w_slot_end) begin
                r_digit <= w_wrap ? '0 : (r_digit + DIGIT_ONE);
            end
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan FSM next state: dead time first, then drive until the slot ends.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK: begin
                if (r_presc == BLANK_LAST) begin
                    w_state_next = DRIVE;
                end else begin
                    w_state_next = BLANK;
                end
            end
            DRIVE: begin
                if (w_slot_end) begin
                    w_state_next = BLANK;
                end else begin
                    w_state_next = DRIVE;
                end
            end
            default: w_state_next = BLANK;
        endcase
    end

    // Shadow capture; the latest load before an apply wins.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_shadow_lz  <= 1'b0;
        end else if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_in;
            r_shadow_lz  <= blank_lz;
        end
    end

    // Pending flag: a load on the wrap cycle keeps it set for the next frame.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_pending <= 1'b0;
        end else if (load) begin
            r_pending <= 1'b1;
        end else if (w_wrap) begin
            r_pending <= 1'b0;
        end
    end

    // Active copy updates only at a frame wrap, so no frame shows a torn value.
    // On a coincident load the shadow still holds the previous contents here.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_act_val <= '0;
            r_act_dp  <= '0;
            r_act_lz  <= 1'b0;
        end else if (w_wrap && r_pending) begin
            r_act_val <= r_shadow_val;
            r_act_dp  <= r_shadow_dp;
            r_act_lz  <= r_shadow_lz;
        end
    end

    // Leading-zero mask: scan from the most significant digit down and stop
    // marking once a nonzero nibble is seen. Digit 0 is never marked.
    always_comb begin
        logic w_run_zero;
        w_run_zero   = 1'b1;
        w_blank_mask = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run_zero      = w_run_zero & (r_act_val[4*k +: 4] == 4'h0);
            w_blank_mask[k] = w_run_zero & r_act_lz;
        end
    end

    assign w_nibble      = 4'(r_act_val >> {r_digit, 2'b00});
    assign w_digit_blank = w_blank_mask[r_digit];
    assign w_digit_dp    = r_act_dp[r_digit];
    assign w_onehot      = AN_BIT0 << r_digit;

    seg7_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_on)
    );

    // Next output pattern for the current scan position.
    always_comb begin
        w_seg_n_next = seg_active_low(SEG_OFF);
        w_dp_n_next  = 1'b1;
        w_an_n_next  = AN_ALL_OFF;
        case (r_state)
            BLANK: begin
                w_seg_n_next = seg_active_low(SEG_OFF);
                w_dp_n_next  = 1'b1;
                w_an_n_next  = AN_ALL_OFF;
            end
            DRIVE: begin
                if (w_digit_blank) begin
                    // A blanked digit is lit only to show its decimal point.
                    w_seg_n_next = seg_active_low(SEG_OFF);
                    if (w_digit_dp) begin
                        w_dp_n_next = 1'b0;
                        w_an_n_next = ~w_onehot;
                    end else begin
                        w_dp_n_next = 1'b1;
                        w_an_n_next = AN_ALL_OFF;
                    end
                end else begin
                    w_seg_n_next = seg_active_low(w_seg_on);
                    w_dp_n_next  = ~w_digit_dp;
                    w_an_n_next  = ~w_onehot;
                end
            end
            default: begin
                w_seg_n_next = seg_active_low(SEG_OFF);
                w_dp_n_next  = 1'b1;
                w_an_n_next  = AN_ALL_OFF;
            end
        endcase
    end

    // Output registers: outputs trail the scan state by one clock.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_seg_n      <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_an_n       <= AN_ALL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg_n      <= w_seg_n_next;
            r_dp_n       <= w_dp_n_next;
            r_an_n       <= w_an_n_next;
            r_frame_done <= w_wrap;
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=4, PRESCALE_N=4,
// BLANK_CYCLES=2. A frame-position model predicts every output each clock;
// hand-computed literal checks pin the model at chosen edges.
// Edge numbering: edge 1 is the first rising edge with n_reset high; outputs
// seen after edge n reflect scan position n-1 of the frame sequence.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int PN     = 4;
    localparam int BC     = 2;
    localparam int SLOT   = 16;
    localparam int FRAME  = 64;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .PRESCALE_N   (PN),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    // Model state
    int          n = 0;
    logic        model_valid = 1'b0;
    logic [15:0] m_val, m_sh_val;
    logic [3:0]  m_dp, m_sh_dp;
    logic        m_lz, m_sh_lz, m_pend;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_fd;

    logic        watch_1111 = 1'b0;
    int          seen_1111 = 0;

    function automatic logic [6:0] hex_seg_n(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
            end
        end
    endtask

    task automatic lit_out(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
        cmp({tag, ".an_n"},  {28'h0, an_n},  {28'h0, e_an});
        cmp({tag, ".seg_n"}, {25'h0, seg_n}, {25'h0, e_seg});
        cmp({tag, ".dp_n"},  {31'h0, dp_n},  {31'h0, e_dp});
    endtask

    task automatic lit_fd(input string tag, input logic e_fd);
        cmp({tag, ".frame_done"}, {31'h0, frame_done}, {31'h0, e_fd});
    endtask

    // Advance to the negative edge following rising edge number k.
    task automatic goto(input int k);
        int g;
        g = 0;
        while (n < k && g < 2000) begin
            @(negedge clk);
            g++;
        end
        cmp("goto_edge", n, k);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        value    = v;
        dp_in    = dp;
        blank_lz = lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Frame-position model: derive slot/digit from the edge count, apply
    // shadow at every 64th edge, capture loads after the apply decision.
    always @(posedge clk) begin
        int s, c, d;
        logic [15:0] upper;
        logic [3:0]  oh;
        logic        blank;
        if (n_reset !== 1'b1) begin
            n = 0;
            model_valid = 1'b1;
            m_val = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
            m_sh_val = 16'h0; m_sh_dp = 4'h0; m_sh_lz = 1'b0; m_pend = 1'b0;
            exp_seg = 7'b1111111; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
        end else if (model_valid) begin
            n = n + 1;
            s = n - 1;
            c = s % SLOT;
            d = (s / SLOT) % DIGITS;
            exp_fd  = ((n % FRAME) == 0);
            exp_seg = 7'b1111111; exp_dp = 1'b1; exp_an = 4'hF;
            if (c >= BC) begin
                upper = m_val >> (4 * d);
                oh    = 4'b0001 << d;
                blank = m_lz && (d != 0) && (upper == 16'h0);
                if (blank) begin
                    if (m_dp[d]) begin
                        exp_an = ~oh;
                        exp_dp = 1'b0;
                    end
                end else begin
                    exp_seg = hex_seg_n(upper[3:0]);
                    exp_an  = ~oh;
                    exp_dp  = ~m_dp[d];
                end
            end
            if (exp_fd && m_pend) begin
                m_val = m_sh_val; m_dp = m_sh_dp; m_lz = m_sh_lz; m_pend = 1'b0;
            end
            if (load === 1'b1) begin
                m_sh_val = value; m_sh_dp = dp_in; m_sh_lz = blank_lz; m_pend = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            cmp("model.seg_n",      {25'h0, seg_n},      {25'h0, exp_seg});
            cmp("model.dp_n",       {31'h0, dp_n},       {31'h0, exp_dp});
            cmp("model.an_n",       {28'h0, an_n},       {28'h0, exp_an});
            cmp("model.frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
            if (watch_1111 && an_n != 4'hF && seg_n == 7'b1111001) begin
                seen_1111++;
            end
        end
    end

    initial begin
        n_reset  = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        lit_out("reset", 4'b1111, 7'b1111111, 1'b1);
        lit_fd("reset", 1'b0);
        n_reset = 1'b1;

        // Idle scan of the reset value "0000"
        goto(2);   lit_out("idle_e2",  4'b1111, 7'b1111111, 1'b1);
        goto(3);   lit_out("idle_e3",  4'b1110, 7'b1000000, 1'b1);
        goto(16);  lit_out("idle_e16", 4'b1110, 7'b1000000, 1'b1);
        goto(17);  lit_out("idle_e17", 4'b1111, 7'b1111111, 1'b1);
        goto(19);  lit_out("idle_e19", 4'b1101, 7'b1000000, 1'b1);
        goto(64);  lit_out("idle_e64", 4'b0111, 7'b1000000, 1'b1); lit_fd("idle_e64", 1'b1);
        goto(65);  lit_out("idle_e65", 4'b1111, 7'b1111111, 1'b1); lit_fd("idle_e65", 1'b0);
        goto(128); lit_fd("idle_e128", 1'b1);

        // 8A1F with dp on digit 2
        goto(200);
        do_load(16'h8A1F, 4'b0100, 1'b0);
        for (int g = 0; g < 100 && frame_done !== 1'b1; g++) @(negedge clk);
        cmp("fd_wait_edge", n, 256);
        goto(258); lit_out("8a1f_blank", 4'b1111, 7'b1111111, 1'b1);
        goto(259); lit_out("8a1f_d0", 4'b1110, 7'b0001110, 1'b1);
        goto(275); lit_out("8a1f_d1", 4'b1101, 7'b1111001, 1'b1);
        goto(291); lit_out("8a1f_d2", 4'b1011, 7'b0001000, 1'b0);
        goto(307); lit_out("8a1f_d3", 4'b0111, 7'b0000000, 1'b1);

        // 0050 with blanking: digits 3 and 2 are leading zeros
        goto(320);
        do_load(16'h0050, 4'b0000, 1'b1);
        goto(390); lit_out("0050_d0", 4'b1110, 7'b1000000, 1'b1);
        goto(410); lit_out("0050_d1", 4'b1101, 7'b0010010, 1'b1);
        goto(425); lit_out("0050_d2", 4'b1111, 7'b1111111, 1'b1);
        goto(440); lit_out("0050_d3", 4'b1111, 7'b1111111, 1'b1);

        // 0000 with blanking: only digit 0 lit
        goto(450);
        do_load(16'h0000, 4'b0000, 1'b1);
        goto(520); lit_out("0000_d0", 4'b1110, 7'b1000000, 1'b1);
        goto(540); lit_out("0000_d1", 4'b1111, 7'b1111111, 1'b1);
        goto(570); lit_out("0000_d3", 4'b1111, 7'b1111111, 1'b1);

        // Blanked digit with dp set shows only the point
        goto(580);
        do_load(16'h0000, 4'b0100, 1'b1);
        goto(680); lit_out("blankdp_d2", 4'b1011, 7'b1111111, 1'b0);

        // Two loads in one frame: latest wins
        goto(700);
        watch_1111 = 1'b1;
        goto(704); do_load(16'h1111, 4'b0000, 1'b0);
        goto(709); do_load(16'h2222, 4'b0000, 1'b0);
        goto(775); lit_out("2222_d0", 4'b1110, 7'b0100100, 1'b1);

        // Load on the wrap cycle applies one frame later
        goto(831); do_load(16'h3333, 4'b0000, 1'b0);
        goto(840); lit_out("wrapload_old_d0", 4'b1110, 7'b0100100, 1'b1);
        goto(860); lit_out("wrapload_old_d1", 4'b1101, 7'b0100100, 1'b1);
        goto(900); lit_out("wrapload_new_d0", 4'b1110, 7'b0110000, 1'b1);
        watch_1111 = 1'b0;
        cmp("never_1111", seen_1111, 0);

        // Reset mid-DRIVE discards a pending load and ignores load in reset
        goto(904); do_load(16'h4444, 4'b0000, 1'b0);
        goto(910);
        n_reset = 1'b0;
        value   = 16'h5555;
        load    = 1'b1;
        @(negedge clk);
        lit_out("midreset", 4'b1111, 7'b1111111, 1'b1);
        lit_fd("midreset", 1'b0);
        n_reset = 1'b1;
        load    = 1'b0;
        goto(2);  lit_out("restart_e2", 4'b1111, 7'b1111111, 1'b1);
        goto(3);  lit_out("restart_e3", 4'b1110, 7'b1000000, 1'b1);
        goto(64); lit_fd("restart_e64", 1'b1);
        goto(67); lit_out("restart_e67", 4'b1110, 7'b1000000, 1'b1);
        goto(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
